// File: rtl/spi_txn_arbiter_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM encoding, default
// timing constants and a counter-width helper.
package spi_arb_pkg;

    localparam int unsigned DEF_LEN_W    = 4;
    localparam int unsigned DEF_CS_SETUP = 2;
    localparam int unsigned DEF_CS_HOLD  = 2;
    localparam int unsigned DEF_TIMEOUT  = 64;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StSetup,
        StStart,
        StWait,
        StHold
    } state_t;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester and byte-engine signals of the SPI transaction arbiter.
// master: the arbiter itself; slave: requesters plus byte engine.
interface spi_txn_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [7:0]       tx_byte0;
    logic [7:0]       tx_byte1;
    logic [1:0]       gnt;
    logic             tx_pop;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             done;
    logic             err;
    logic [1:0]       cs_n;
    logic             spi_start;
    logic [7:0]       spi_tx;
    logic [7:0]       spi_rx;
    logic             spi_busy;

    modport master (
        input  req, len0, len1, tx_byte0, tx_byte1, spi_rx, spi_busy,
        output gnt, tx_pop, rx_byte, rx_valid, done, err, cs_n, spi_start, spi_tx
    );

    modport slave (
        output req, len0, len1, tx_byte0, tx_byte1, spi_rx, spi_busy,
        input  gnt, tx_pop, rx_byte, rx_valid, done, err, cs_n, spi_start, spi_tx
    );

endinterface

// File: rtl/spi_txn_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. ptr_q names the requester preferred on the
// next contended grant; it flips away from whoever was last granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic ptr_q;

    // Pick: contention resolved by ptr_q, otherwise the lone requester.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (update && (|req)) begin
            ptr_q <= ~gnt[1];
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Multi-byte SPI transaction controller sharing one mode-0 byte engine
// between two requesters. Optional macro SPI_TIMEOUT_EN adds a per-phase
// watchdog on the engine handshake that aborts with done+err.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned LEN_W    = DEF_LEN_W,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    spi_txn_arbiter_if.master bus
);

    localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PH_W   = cnt_width(PH_MAX);

    if (LEN_W < 1 || CS_SETUP < 1 || CS_HOLD < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("spi_txn_arbiter: LEN_W, CS_SETUP, CS_HOLD and TIMEOUT must be >= 1");
    end

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [1:0]       cs_n_q, cs_n_d;
    logic             start_q, start_d;
    logic [7:0]       tx_q, tx_d;
    logic             pop_q, pop_d;
    logic [7:0]       rx_q, rx_d;
    logic             rxv_q, rxv_d;
    logic             done_q, done_d;
    logic [1:0]       arb_gnt;
    logic [LEN_W-1:0] len_sel;
    logic [7:0]       tx_sel;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .update (state_q == StArb),
        .gnt    (arb_gnt)
    );

    assign len_sel = arb_gnt[1] ? bus.len1 : bus.len0;
    assign tx_sel  = idx_q ? bus.tx_byte1 : bus.tx_byte0;

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned TO_W = cnt_width(TIMEOUT);

    logic [TO_W-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ph_d    = ph_q;
        cs_n_d  = cs_n_q;
        start_d = start_q;
        tx_d    = tx_q;
        pop_d   = 1'b0;
        rx_d    = rx_q;
        rxv_d   = 1'b0;
        done_d  = 1'b0;
`ifdef SPI_TIMEOUT_EN
        err_d   = 1'b0;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                // gnt survives only through the done cycle; done_q blocks an
                // immediate re-arbitration so there is always an idle gap.
                gnt_d = 2'b00;
                if ((|bus.req) && !done_q) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (|arb_gnt) begin
                    gnt_d = arb_gnt;
                    idx_d = arb_gnt[1];
                    rem_d = len_sel;
                    if (len_sel == '0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cs_n_d  = arb_gnt[1] ? 2'b01 : 2'b10;
                        ph_d    = '0;
                        state_d = StSetup;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StSetup: begin
                if (ph_q == PH_W'(CS_SETUP - 1)) begin
                    start_d = 1'b1;
                    tx_d    = tx_sel;
                    state_d = StStart;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            StStart: begin
                if (bus.spi_busy) begin
                    start_d = 1'b0;
                    pop_d   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!bus.spi_busy) begin
                    rx_d  = bus.spi_rx;
                    rxv_d = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        ph_d    = '0;
                        state_d = StHold;
                    end else begin
                        start_d = 1'b1;
                        tx_d    = tx_sel;
                        state_d = StStart;
                    end
                end
            end
            StHold: begin
                if (ph_q == PH_W'(CS_HOLD - 1)) begin
                    cs_n_d  = 2'b11;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SPI_TIMEOUT_EN
        // Watchdog only fires while stuck in an engine phase; any state change
        // reloads it.
        if ((state_q == StStart || state_q == StWait) && state_d == state_q) begin
            if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                start_d = 1'b0;
                cs_n_d  = 2'b11;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        if (state_d != state_q) begin
            tmo_d = '0;
        end
`endif
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            idx_q   <= 1'b0;
            rem_q   <= '0;
            ph_q    <= '0;
            cs_n_q  <= 2'b11;
            start_q <= 1'b0;
            tx_q    <= 8'h00;
            pop_q   <= 1'b0;
            rx_q    <= 8'h00;
            rxv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ph_q    <= ph_d;
            cs_n_q  <= cs_n_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            rx_q    <= rx_d;
            rxv_q   <= rxv_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_TIMEOUT_EN
    // Watchdog counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.spi_start = start_q;
    assign bus.spi_tx    = tx_q;
    assign bus.tx_pop    = pop_q;
    assign bus.rx_byte   = rx_q;
    assign bus.rx_valid  = rxv_q;
    assign bus.done      = done_q;

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Transaction controller sitting in front of the SPI mode 0 byte engine.
- Shares the single byte engine between two requesters, for example the joystick and accelerometer Pmods.
- Runs multi-byte transactions with a per-requester chip select, CS setup/hold timing, round-robin arbitration and a byte-level data handshake to the granted requester.

Parameters:
- LEN_W, 4: width of transaction byte count (max 15 bytes).
- CS_SETUP, 2: clk cycles between cs_n falling and first spi_start.
- CS_HOLD, 2: clk cycles between last byte completion and cs_n rising.
- TIMEOUT, 64: clk cycles allowed per engine phase (used only with SPI_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  2  transaction request per requester; level, held until done
- len0  in  LEN_W  byte count for requester 0, sampled at grant
- len1  in  LEN_W  byte count for requester 1, sampled at grant
- tx_byte0  in  8  next byte to send, requester 0
- tx_byte1  in  8  next byte to send, requester 1
- gnt  out  2  one-hot grant, held for whole transaction
- tx_pop  out  1  1-cycle pulse: current tx byte consumed, requester presents next
- rx_byte  out  8  received byte, valid with rx_valid
- rx_valid  out  1  1-cycle pulse per received byte
- done  out  1  1-cycle pulse at end of transaction, gnt still asserted that cycle
- err  out  1  1-cycle pulse with done on timeout abort (0 when macro off)
- cs_n  out  2  active-low chip select per requester
- spi_start  out  1  start request to byte engine
- spi_tx  out  8  byte to engine, stable while spi_start=1 or spi_busy=1
- spi_rx  in  8  byte from engine
- spi_busy  in  1  engine busy

Behaviour:
- Reset values: gnt=00, cs_n=11, spi_start=0, spi_tx=0, tx_pop=0, rx_valid=0, rx_byte=0, done=0, err=0, state=IDLE, rr pointer=0.
- Reset mid-transaction: all outputs take reset values on the same edge; the engine finishes its byte unobserved.
- IDLE: if any req=1, go to ARB.
- ARB (1 cycle):
  - Round-robin. When both requests are active, grant goes to the requester not granted last; rr pointer is updated on grant.
  - Latch len and the granted index.
  - If len=0: pulse done in the next cycle and return to IDLE, with no cs_n activity.
  - Otherwise go to SETUP.
- SETUP: assert cs_n[idx]=0, count CS_SETUP cycles, go to START.
- START:
  - spi_tx = tx_byte[idx] (registered on entry); spi_start=1.
  - Stay until spi_busy=1, then spi_start=0, tx_pop pulse, go to WAIT.
- WAIT: stay while spi_busy=1. On spi_busy=0, capture spi_rx into rx_byte, pulse rx_valid, decrement remaining count.
  - If remaining count >0, go to START.
  - If remaining count =0, go to HOLD.
- HOLD: count CS_HOLD cycles, set cs_n=11, pulse done, clear gnt, go to IDLE.
- Minimum one idle cycle between transactions; a continuously held req re-arbitrates.
- A req drop mid-transaction is ignored; the transaction runs to len bytes.
- gnt and cs_n never change outside ARB/HOLD. At most one cs_n bit is low at any time.
- Count wrap-around is impossible: the counter only decrements from len≥1 to 0.

Optional Feature:
- SPI_TIMEOUT_EN defined: a cycle counter runs in START and WAIT and reloads at each state entry.
  - On reaching TIMEOUT: drop spi_start, set cs_n=11 immediately, pulse done and err together, go to IDLE.
  - Remaining bytes are discarded; no rx_valid for the aborted byte.
- Undefined: START and WAIT wait indefinitely; err is tied 0.

Decomposition:
- Package spi_arb_pkg: state encoding (IDLE, ARB, SETUP, START, WAIT, HOLD) and default LEN_W/CS_SETUP/CS_HOLD/TIMEOUT constants.
- One natural sub-module: rr_arbiter2, the two-way round-robin picker with pointer register.

Test Plan:
- Single transaction: req=01, len0=3, tx 0xA1,0xA2,0xA3, loopback spi_rx=spi_tx^0xFF -> three tx_pop, rx_byte 0x5E,0x5D,0x5C, cs_n=10 throughout, one done, err=0.
- Contention: req=11, both len=1, held -> grants alternate 01,10,01,10; never both cs_n low.
- Zero length: req=10, len1=0 -> done after ARB, cs_n stays 11, no spi_start, no rx_valid.
- CS timing: CS_SETUP=2, CS_HOLD=2 -> exactly 2 cycles between cs_n fall and spi_start rise, and 2 cycles between last rx_valid and cs_n rise.
- Reset mid-byte: rst during WAIT of byte 2 of 4 -> next cycle cs_n=11, gnt=00; no further rx_valid or done.
- Timeout (SPI_TIMEOUT_EN, TIMEOUT=64): engine holds spi_busy=0 after start -> after 64 cycles done=err=1, cs_n=11; without the macro the controller stays in START.
